// File: rtl/usb_cdc_sync_fifo_if.sv
// usb_cdc_sync_fifo_if: control, data and status bundle between a FIFO and its user
interface usb_cdc_sync_fifo_if #(
  parameter int DW = 8,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH + 1);
  logic flush;
  logic wr;
  logic [DW-1:0] w_data;
  logic rd;
  logic [DW-1:0] r_data;
  logic full;
  logic empty;
  logic [LW-1:0] level;
  logic [LW-1:0] th_above;
  logic [LW-1:0] th_below;
  logic level_above;
  logic level_below;
  logic overflow;
  logic underflow;
  logic clr_err;
  modport master (
    output flush, wr, w_data, rd, th_above, th_below, clr_err,
    input r_data, full, empty, level, level_above, level_below, overflow, underflow
  );
  modport slave (
    input flush, wr, w_data, rd, th_above, th_below, clr_err,
    output r_data, full, empty, level, level_above, level_below, overflow, underflow
  );
endinterface

// File: rtl/usb_cdc_sync_fifo.sv
// usb_cdc_sync_fifo: single-clock FWFT FIFO of any depth with flush, thresholds and sticky errors
module usb_cdc_sync_fifo #(
  parameter int DW = 8,
  parameter int DEPTH = 16
) (
  input logic clk,
  input logic rst,
  usb_cdc_sync_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] w_ptr, r_ptr;
  logic [LW-1:0] level, level_next;
  logic full, empty, overflow, underflow, rd_ok, wr_ok;
  assign rd_ok = bus.rd & ~empty;
  assign wr_ok = bus.wr & (~full | rd_ok);
  assign level_next = level + LW'(wr_ok) - LW'(rd_ok);
  // pointers, occupancy and sticky error flags; flush clears all but the flags
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
      level <= '0;
      empty <= 1'b1;
      full <= 1'b0;
      overflow <= rst ? 1'b0 : overflow;
      underflow <= rst ? 1'b0 : underflow;
    end else begin
      w_ptr <= wr_ok ? (w_ptr == AW'(DEPTH - 1) ? '0 : w_ptr + 1'b1) : w_ptr;
      r_ptr <= rd_ok ? (r_ptr == AW'(DEPTH - 1) ? '0 : r_ptr + 1'b1) : r_ptr;
      level <= level_next;
      empty <= level_next == '0;
      full <= level_next == LW'(DEPTH);
      overflow <= (overflow & ~bus.clr_err) | (bus.wr & ~wr_ok);
      underflow <= (underflow & ~bus.clr_err) | (bus.rd & empty);
    end
  end
  // storage is never cleared; only accepted writes outside reset/flush land
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && wr_ok) mem[w_ptr] <= bus.w_data;
  end
  assign bus.r_data = mem[r_ptr];
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.level = level;
  assign bus.overflow = overflow;
  assign bus.underflow = underflow;
  assign bus.level_above = level > bus.th_above;
  assign bus.level_below = level < bus.th_below;
endmodule

// File: tb/tb_usb_cdc_sync_fifo.sv
// tb_usb_cdc_sync_fifo: directed checks on a 16x8 and a 5x8 FIFO instance
module tb_usb_cdc_sync_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  usb_cdc_sync_fifo_if #(.DW(8), .DEPTH(16)) ia ();
  usb_cdc_sync_fifo_if #(.DW(8), .DEPTH(5)) ib ();
  usb_cdc_sync_fifo #(.DW(8), .DEPTH(16)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  usb_cdc_sync_fifo #(.DW(8), .DEPTH(5)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  logic [7:0] q [$];
  int sent, got_n;
  logic w, r, rok, wok;
  logic [0:5] ab_exp = 6'b000011;
  logic [0:5] bl_exp = 6'b110000;
  initial begin
    {ia.flush, ia.wr, ia.rd, ia.clr_err, ia.w_data, ia.th_below} = '0;
    {ib.flush, ib.wr, ib.rd, ib.clr_err, ib.w_data, ib.th_below} = '0;
    ia.th_above = 5'd16;
    ib.th_above = 3'd5;
    step();
    step();
    rst = 1'b0;
    chk("rst_empty", ia.empty, 1);
    chk("rst_full", ia.full, 0);
    chk("rst_level", ia.level, 0);
    chk("rst_ovf", ia.overflow, 0);
    chk("rst_unf", ia.underflow, 0);
    chk("rst_below_th0", ia.level_below, 0);
    for (int i = 0; i < 16; i++) begin
      ia.wr = 1'b1;
      ia.w_data = 8'(i);
      step();
    end
    ia.wr = 1'b0;
    chk("fill_full", ia.full, 1);
    chk("fill_level", ia.level, 16);
    chk("above_th_depth", ia.level_above, 0);
    ia.wr = 1'b1;
    ia.w_data = 8'hFF;
    step();
    ia.wr = 1'b0;
    chk("ovf_set", ia.overflow, 1);
    chk("ovf_level", ia.level, 16);
    chk("ovf_head", ia.r_data, 8'h00);
    ia.wr = 1'b1;
    ia.rd = 1'b1;
    ia.w_data = 8'hA5;
    step();
    ia.wr = 1'b0;
    ia.rd = 1'b0;
    chk("rdwr_full_level", ia.level, 16);
    chk("rdwr_full_full", ia.full, 1);
    chk("rdwr_full_ovf", ia.overflow, 1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", ia.r_data, i < 15 ? 8'(i + 1) : 8'hA5);
      ia.rd = 1'b1;
      step();
    end
    ia.rd = 1'b0;
    chk("drain_empty", ia.empty, 1);
    chk("drain_level", ia.level, 0);
    chk("drain_unf", ia.underflow, 0);
    ia.clr_err = 1'b1;
    step();
    ia.clr_err = 1'b0;
    chk("clr_ovf", ia.overflow, 0);
    ia.wr = 1'b1;
    ia.rd = 1'b1;
    ia.w_data = 8'h3C;
    step();
    ia.wr = 1'b0;
    ia.rd = 1'b0;
    chk("rdwr_empty_level", ia.level, 1);
    chk("rdwr_empty_empty", ia.empty, 0);
    chk("rdwr_empty_data", ia.r_data, 8'h3C);
    chk("rdwr_empty_unf", ia.underflow, 1);
    ia.rd = 1'b1;
    step();
    chk("pop_3c_empty", ia.empty, 1);
    ia.clr_err = 1'b1;
    step();
    chk("clr_vs_new_unf", ia.underflow, 1);
    ia.rd = 1'b0;
    step();
    ia.clr_err = 1'b0;
    chk("clr_unf", ia.underflow, 0);
    ia.th_above = 5'd3;
    ia.th_below = 5'd2;
    step();
    for (int l = 0; l <= 5; l++) begin
      chk("th_up_above", ia.level_above, ab_exp[l]);
      chk("th_up_below", ia.level_below, bl_exp[l]);
      if (l < 5) begin
        ia.wr = 1'b1;
        ia.w_data = 8'(l);
        step();
        ia.wr = 1'b0;
      end
    end
    for (int l = 4; l >= 0; l--) begin
      ia.rd = 1'b1;
      step();
      ia.rd = 1'b0;
      chk("th_dn_level", ia.level, l);
      chk("th_dn_above", ia.level_above, ab_exp[l]);
      chk("th_dn_below", ia.level_below, bl_exp[l]);
    end
    for (int i = 0; i < 7; i++) begin
      ia.wr = 1'b1;
      ia.w_data = 8'(8'h20 + i);
      step();
    end
    chk("pre_flush_level", ia.level, 7);
    ia.flush = 1'b1;
    ia.w_data = 8'h77;
    step();
    ia.flush = 1'b0;
    ia.wr = 1'b0;
    chk("flush_level", ia.level, 0);
    chk("flush_empty", ia.empty, 1);
    chk("flush_ovf", ia.overflow, 0);
    chk("flush_unf", ia.underflow, 0);
    ia.wr = 1'b1;
    ia.w_data = 8'h11;
    step();
    ia.wr = 1'b0;
    chk("post_flush_data", ia.r_data, 8'h11);
    chk("post_flush_level", ia.level, 1);
    sent = 0;
    got_n = 0;
    for (int c = 0; c < 400 && got_n < 12; c++) begin
      w = (sent < 12) && ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 2) == 0;
      rok = r && q.size() > 0;
      wok = w && (q.size() < 5 || rok);
      ib.wr = w;
      ib.rd = r;
      ib.w_data = 8'(8'h40 + sent);
      step();
      if (rok) begin
        void'(q.pop_front());
        got_n++;
      end
      if (wok) begin
        q.push_back(8'(8'h40 + sent));
        sent++;
      end
      chk("d5_level", ib.level, q.size());
      chk("d5_full", ib.full, q.size() == 5);
      if (q.size() > 0) chk("d5_data", ib.r_data, q[0]);
    end
    ib.wr = 1'b0;
    ib.rd = 1'b0;
    chk("d5_all_read", got_n, 12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
